// File: rtl/board_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// board_fetch_ctrl_if
// Game-logic side of the board tile memory controller.
//   iWr_req     : write request, level, held until oWr_ack is seen
//   iWr_cell_x  : target cell column (6 bits), stable from request to ack
//   iWr_cell_y  : target cell row (5 bits), stable from request to ack
//   iWr_ent     : entity code to store (2 bits)
//   oWr_ack     : one-cycle pulse, write done (or dropped if out of range)
//   iClear_req  : start a board-clear sweep, sampled every cycle
//   oClear_busy : clear sweep in progress
// master = game logic, slave = board_fetch_ctrl.
// -----------------------------------------------------------------------------
interface board_fetch_ctrl_if;
    logic       iWr_req;
    logic [5:0] iWr_cell_x;
    logic [4:0] iWr_cell_y;
    logic [1:0] iWr_ent;
    logic       oWr_ack;
    logic       iClear_req;
    logic       oClear_busy;

    modport master (
        output iWr_req, iWr_cell_x, iWr_cell_y, iWr_ent, iClear_req,
        input  oWr_ack, oClear_busy
    );

    modport slave (
        input  iWr_req, iWr_cell_x, iWr_cell_y, iWr_ent, iClear_req,
        output oWr_ack, oClear_busy
    );
endinterface

// File: rtl/board_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// board_fetch_ctrl
// Owns the game-board tile memory (one 2-bit entity code per 16x16 cell) and
// feeds the sprite-draw datapath the entity code of the current pixel with a
// latency of two cycles, aligned with delayed pixel coordinates.
// The single memory port is shared between:
//   - the VGA read path (active video only),
//   - game-logic writes (req/ack handshake, committed during blank only),
//   - a board-clear sweep (writes NOTHING_CODE during blank only).
// Ports:
//   iVGA_CLK        : pixel clock, the only clock
//   iReset          : asynchronous active-high reset
//   ivga_x, ivga_y  : current pixel coordinates
//   bus (slave)     : write handshake and clear control, see board_fetch_ctrl_if
//   oSprite         : entity code for the pixel two cycles back
//   ovga_x, ovga_y  : ivga_x/ivga_y delayed by two cycles
// -----------------------------------------------------------------------------
module board_fetch_ctrl #(
    parameter int         H_ACTIVE     = 640,
    parameter int         V_ACTIVE     = 480,
    parameter int         CELL_SHIFT   = 4,
    parameter int         H_CELLS      = H_ACTIVE >> CELL_SHIFT,
    parameter int         V_CELLS      = V_ACTIVE >> CELL_SHIFT,
    parameter logic [1:0] NOTHING_CODE = 2'd3
) (
    input  logic                     iVGA_CLK,
    input  logic                     iReset,
    input  logic [9:0]               ivga_x,
    input  logic [9:0]               ivga_y,
    board_fetch_ctrl_if.slave        bus,
    output logic [1:0]               oSprite,
    output logic [9:0]               ovga_x,
    output logic [9:0]               ovga_y
);

    localparam int                  N_CELLS   = H_CELLS * V_CELLS;
    localparam int                  ADDR_W    = 11;
    localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(N_CELLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WACK  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Linear cell address: row-major, H_CELLS cells per row.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [9:0] cell_y,
                                                    input logic [9:0] cell_x);
        return ADDR_W'(cell_y) * ADDR_W'(H_CELLS) + ADDR_W'(cell_x);
    endfunction

    logic [1:0]        mem_r [0:N_CELLS-1];

    state_t            state_r;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic              wr_ack_r;
    logic              clear_busy_r;

    logic              active_s;
    logic              wr_in_range_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [1:0]        mem_wdata_s;

    logic [1:0]        rd_data_r;
    logic              act1_r;
    logic [9:0]        x_d1_r;
    logic [9:0]        y_d1_r;

    assign active_s      = (ivga_x < 10'(H_ACTIVE)) && (ivga_y < 10'(V_ACTIVE));
    assign wr_in_range_s = (bus.iWr_cell_x < 6'(H_CELLS)) && (bus.iWr_cell_y < 5'(V_CELLS));
    assign rd_addr_s     = cell_addr(ivga_y >> CELL_SHIFT, ivga_x >> CELL_SHIFT);
    assign wr_addr_s     = cell_addr(10'(bus.iWr_cell_y), 10'(bus.iWr_cell_x));

    assign bus.oWr_ack     = wr_ack_r;
    assign bus.oClear_busy = clear_busy_r;

    // Write-port selection: both writers are confined to blank cycles, so the
    // write port never collides with the active-video read.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = {ADDR_W{1'b0}};
        mem_wdata_s = NOTHING_CODE;
        case (state_r)
            ST_IDLE: begin
                // Out-of-range requests are still acked but never touch memory.
                if (!bus.iClear_req && bus.iWr_req && !active_s && wr_in_range_s) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = wr_addr_s;
                    mem_wdata_s = bus.iWr_ent;
                end else begin
                    mem_we_s    = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (!active_s) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = clr_cnt_r;
                    mem_wdata_s = NOTHING_CODE;
                end else begin
                    mem_we_s    = 1'b0;
                end
            end
            default: begin
                mem_we_s = 1'b0;
            end
        endcase
    end

    // Tile memory: contents are not reset; read is synchronous and performed
    // only during active video (stage 1 of the read pipeline).
    always_ff @(posedge iVGA_CLK) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
        if (active_s) begin
            rd_data_r <= mem_r[rd_addr_s];
        end
    end

    // Read pipeline: stage 1 active flag and coordinates, stage 2 outputs.
    always_ff @(posedge iVGA_CLK or posedge iReset) begin
        if (iReset) begin
            act1_r  <= 1'b0;
            x_d1_r  <= 10'd0;
            y_d1_r  <= 10'd0;
            ovga_x  <= 10'd0;
            ovga_y  <= 10'd0;
            oSprite <= NOTHING_CODE;
        end else begin
            act1_r  <= active_s;
            x_d1_r  <= ivga_x;
            y_d1_r  <= ivga_y;
            ovga_x  <= x_d1_r;
            ovga_y  <= y_d1_r;
            // rd_data_r is only meaningful when stage 1 saw active video.
            oSprite <= act1_r ? rd_data_r : NOTHING_CODE;
        end
    end

    // Arbitration FSM with registered ack and busy; reset lands in CLEAR so
    // the board self-clears after every reset.
    always_ff @(posedge iVGA_CLK or posedge iReset) begin
        if (iReset) begin
            state_r      <= ST_CLEAR;
            clr_cnt_r    <= {ADDR_W{1'b0}};
            wr_ack_r     <= 1'b0;
            clear_busy_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.iClear_req) begin
                        // Clear wins over a simultaneous write request.
                        state_r      <= ST_CLEAR;
                        clr_cnt_r    <= {ADDR_W{1'b0}};
                        wr_ack_r     <= 1'b0;
                        clear_busy_r <= 1'b1;
                    end else if (bus.iWr_req && !active_s) begin
                        state_r      <= ST_WACK;
                        wr_ack_r     <= 1'b1;
                        clear_busy_r <= 1'b0;
                    end else begin
                        state_r      <= ST_IDLE;
                        wr_ack_r     <= 1'b0;
                        clear_busy_r <= 1'b0;
                    end
                end
                ST_WACK: begin
                    // Ack cycle: the still-high request must not re-commit.
                    state_r      <= ST_IDLE;
                    wr_ack_r     <= 1'b0;
                    clear_busy_r <= 1'b0;
                end
                ST_CLEAR: begin
                    wr_ack_r <= 1'b0;
                    if (!active_s) begin
                        if (clr_cnt_r == LAST_ADDR) begin
                            // Counter stays at its terminal value (no wrap).
                            state_r      <= ST_IDLE;
                            clear_busy_r <= 1'b0;
                        end else begin
                            clr_cnt_r    <= clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                            clear_busy_r <= 1'b1;
                        end
                    end else begin
                        // Active video owns the port: sweep stalls in place.
                        clear_busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_CLEAR;
                    clr_cnt_r    <= {ADDR_W{1'b0}};
                    wr_ack_r     <= 1'b0;
                    clear_busy_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_board_fetch_ctrl
// Scoreboard bench: each pixel driven pushes its expected (x, y, sprite) from a
// reference board model; the entry is popped and compared when the DUT's two
// cycle pipeline delivers it. Handshake and clear timing are checked directly.
// -----------------------------------------------------------------------------
module tb_board_fetch_ctrl;

    localparam int N_CELLS = 1200;

    logic       iVGA_CLK = 1'b0;
    logic       iReset   = 1'b1;
    logic [9:0] ivga_x;
    logic [9:0] ivga_y;
    logic [1:0] oSprite;
    logic [9:0] ovga_x;
    logic [9:0] ovga_y;

    board_fetch_ctrl_if bus();

    board_fetch_ctrl dut (
        .iVGA_CLK (iVGA_CLK),
        .iReset   (iReset),
        .ivga_x   (ivga_x),
        .ivga_y   (ivga_y),
        .bus      (bus),
        .oSprite  (oSprite),
        .ovga_x   (ovga_x),
        .ovga_y   (ovga_y)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] spr;
    } exp_t;

    exp_t       sb_q[$];
    logic [1:0] ref_board [0:N_CELLS-1];

    int         vec_cnt    = 0;
    int         miscmp_cnt = 0;
    int         ack_cnt    = 0;
    int         ack_x      = -1;
    bit         wr_pend    = 1'b0;
    bit         pend_ok    = 1'b0;
    int         pend_addr  = 0;
    logic [1:0] pend_ent   = 2'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] expect_sprite(input logic [9:0] x, input logic [9:0] y);
        if (x < 10'd640 && y < 10'd480) begin
            return ref_board[int'(y >> 4) * 40 + int'(x >> 4)];
        end
        return 2'd3;
    endfunction

    // One pixel clock: observe ack in its own cycle, push the expectation for
    // the pixel now on the inputs, advance, and retire pixels two cycles old.
    task automatic tick();
        exp_t e;
        if (bus.oWr_ack === 1'b1) begin
            ack_cnt++;
            ack_x = int'(ivga_x);
            if (wr_pend && pend_ok) ref_board[pend_addr] = pend_ent;
            wr_pend     = 1'b0;
            bus.iWr_req = 1'b0;
        end
        e.x   = ivga_x;
        e.y   = ivga_y;
        e.spr = expect_sprite(ivga_x, ivga_y);
        sb_q.push_back(e);
        @(posedge iVGA_CLK);
        #1;
        while (sb_q.size() > 1) begin
            e = sb_q.pop_front();
            check_eq("sprite", 32'(oSprite), 32'(e.spr));
            check_eq("ovga_x", 32'(ovga_x), 32'(e.x));
            check_eq("ovga_y", 32'(ovga_y), 32'(e.y));
        end
    endtask

    task automatic run_x(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) begin
            ivga_x = 10'(x);
            ivga_y = 10'(y);
            tick();
        end
    endtask

    // One pixel inside every cell.
    task automatic scan_all_cells();
        for (int cy = 0; cy < 30; cy++) begin
            for (int cx = 0; cx < 40; cx++) begin
                ivga_x = 10'(cx * 16 + 7);
                ivga_y = 10'(cy * 16 + 9);
                tick();
            end
        end
    endtask

    task automatic start_write(input int cx, input int cy, input logic [1:0] ent);
        bus.iWr_cell_x = 6'(cx);
        bus.iWr_cell_y = 5'(cy);
        bus.iWr_ent    = ent;
        bus.iWr_req    = 1'b1;
        wr_pend        = 1'b1;
        pend_ok        = (cx < 40) && (cy < 30);
        pend_addr      = cy * 40 + cx;
        pend_ent       = ent;
        ack_cnt        = 0;
        ack_x          = -1;
    endtask

    task automatic blank_write(input int cx, input int cy, input logic [1:0] ent);
        ivga_x = 10'd700;
        ivga_y = 10'd0;
        start_write(cx, cy, ent);
        for (int i = 0; i < 8 && wr_pend; i++) tick();
        for (int i = 0; i < 3; i++) tick();
        check_eq("blank_wr_ack_pulses", 32'(ack_cnt), 32'd1);
    endtask

    // Count blank cycles spent with oClear_busy high (bounded).
    task automatic wait_clear(output int n);
        n      = 0;
        ivga_x = 10'd700;
        ivga_y = 10'd0;
        while (bus.oClear_busy === 1'b1 && n < 3000) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < N_CELLS; i++) ref_board[i] = 2'd3;
        ivga_x         = 10'd700;
        ivga_y         = 10'd0;
        bus.iWr_req    = 1'b0;
        bus.iWr_cell_x = 6'd0;
        bus.iWr_cell_y = 5'd0;
        bus.iWr_ent    = 2'd0;
        bus.iClear_req = 1'b0;

        // 1: reset values, self-clear of exactly 1200 blank cycles.
        #23;
        check_eq("rst_sprite", 32'(oSprite), 32'd3);
        check_eq("rst_ovga_x", 32'(ovga_x), 32'd0);
        check_eq("rst_ovga_y", 32'(ovga_y), 32'd0);
        check_eq("rst_ack", 32'(bus.oWr_ack), 32'd0);
        check_eq("rst_busy", 32'(bus.oClear_busy), 32'd1);
        @(negedge iVGA_CLK);
        iReset = 1'b0;
        sb_q.delete();
        wait_clear(n);
        check_eq("init_clear_cycles", 32'(n), 32'd1200);
        scan_all_cells();

        // 2: blank write, ack one cycle later, then read back with neighbours.
        ivga_x = 10'd650;
        ivga_y = 10'd0;
        start_write(5, 2, 2'd1);
        tick();
        run_x(0, 651, 660);
        check_eq("wr_blank_ack_cnt", 32'(ack_cnt), 32'd1);
        check_eq("wr_blank_ack_x", 32'(ack_x), 32'd651);
        run_x(32, 64, 111);

        // 3: request raised during active video waits for blank.
        ivga_x = 10'd100;
        ivga_y = 10'd10;
        start_write(10, 3, 2'd2);
        run_x(10, 100, 700);
        check_eq("wr_active_ack_cnt", 32'(ack_cnt), 32'd1);
        check_eq("wr_active_ack_x", 32'(ack_x), 32'd641);
        run_x(48, 144, 191);

        // 4: clear beats a simultaneous write; write completes afterwards.
        ivga_x = 10'd700;
        ivga_y = 10'd0;
        bus.iClear_req = 1'b1;
        start_write(20, 10, 2'd0);
        tick();
        bus.iClear_req = 1'b0;
        wait_clear(n);
        check_eq("clr_wr_sweep_cycles", 32'(n), 32'd1200);
        check_eq("clr_wr_ack_in_sweep", 32'(ack_cnt), 32'd0);
        for (int i = 0; i < N_CELLS; i++) ref_board[i] = 2'd3;
        for (int i = 0; i < 8 && wr_pend; i++) tick();
        check_eq("clr_wr_ack_after", 32'(ack_cnt), 32'd1);
        run_x(160, 304, 351);

        // 5: out-of-range write is acked but leaves the board untouched.
        blank_write(45, 2, 2'd1);
        scan_all_cells();

        // 6: clear started mid-line stalls on active video.
        blank_write(0, 1, 2'd1);
        blank_write(39, 1, 2'd1);
        blank_write(0, 0, 2'd2);
        ivga_x = 10'd600;
        ivga_y = 10'd0;
        bus.iClear_req = 1'b1;
        tick();
        bus.iClear_req = 1'b0;
        run_x(0, 601, 679);
        for (int i = 0; i < 40; i++) ref_board[i] = 2'd3;
        check_eq("stall_busy", 32'(bus.oClear_busy), 32'd1);
        run_x(16, 0, 639);
        run_x(16, 640, 679);
        for (int i = 40; i < 80; i++) ref_board[i] = 2'd3;
        run_x(16, 0, 639);
        run_x(0, 0, 15);
        wait_clear(n);
        check_eq("stall_rest_cycles", 32'(n), 32'd1120);
        for (int i = 0; i < N_CELLS; i++) ref_board[i] = 2'd3;
        scan_all_cells();

        ivga_x = 10'd700;
        ivga_y = 10'd0;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
